// File: rtl/control_seq_if.sv
// control_seq_if
//   Bundles the sequencer's program-memory and ALU signals.
//   master : sequencer side (drives fetch_req, pc_out, alu_op, operand_out,
//            acc_we, halted; receives instr_in, instr_valid, ALU flags)
//   slave  : memory/ALU side (the reverse directions)
//   Signals:
//     instr_in    ADDR_WIDTH+DATA_WIDTH  opcode (upper) + operand (lower)
//     instr_valid 1                      word for pc_out is valid
//     zero_f, ls_z_f, gr_z_f  1 each     ALU result flags
//     fetch_req   1                      request for word at pc_out
//     pc_out      CNTR_WIDTH             program counter
//     alu_op      ADDR_WIDTH             operation to the ALU
//     operand_out DATA_WIDTH             ALU second operand
//     acc_we      1                      accumulator write strobe
//     halted      1                      sequencer stopped
interface control_seq_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int CNTR_WIDTH = 8
);
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] instr_in;
  logic                             instr_valid;
  logic                             zero_f;
  logic                             ls_z_f;
  logic                             gr_z_f;
  logic                             fetch_req;
  logic [CNTR_WIDTH-1:0]            pc_out;
  logic [ADDR_WIDTH-1:0]            alu_op;
  logic [DATA_WIDTH-1:0]            operand_out;
  logic                             acc_we;
  logic                             halted;

  modport master (
    input  instr_in, instr_valid, zero_f, ls_z_f, gr_z_f,
    output fetch_req, pc_out, alu_op, operand_out, acc_we, halted
  );

  modport slave (
    output instr_in, instr_valid, zero_f, ls_z_f, gr_z_f,
    input  fetch_req, pc_out, alu_op, operand_out, acc_we, halted
  );
endinterface

// File: rtl/control_seq.sv
// control_seq
//   Instruction sequencer: fetches a word from program memory, decodes it,
//   drives the ALU (or resolves a jump / halt) and advances the PC.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    control_seq_if.master (memory handshake + ALU control)
//   Opcode map (ADDR_WIDTH >= 5):
//     0..17 ALU ops NOP,ADDi,ADDr,SUBi,SUBr,ANDi,ANDr,ORi,ORr,XORi,XORr,
//           INC,DEC,NOT,SHL,SHR,LDi,LDr
//     18 JMP, 19 JZ, 20 JLZ, 21 JGZ, 22 HLT, others unknown
module control_seq #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int CNTR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  control_seq_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] OP_NOP = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OP_LDR = ADDR_WIDTH'(17);
  localparam logic [ADDR_WIDTH-1:0] OP_JMP = ADDR_WIDTH'(18);
  localparam logic [ADDR_WIDTH-1:0] OP_JZ  = ADDR_WIDTH'(19);
  localparam logic [ADDR_WIDTH-1:0] OP_JLZ = ADDR_WIDTH'(20);
  localparam logic [ADDR_WIDTH-1:0] OP_JGZ = ADDR_WIDTH'(21);
  localparam logic [ADDR_WIDTH-1:0] OP_HLT = ADDR_WIDTH'(22);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t                           state;
  state_t                           state_nxt;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] ir;
  logic [CNTR_WIDTH-1:0]            pc;
  logic [CNTR_WIDTH-1:0]            pc_nxt;
  logic [CNTR_WIDTH-1:0]            pc_plus;
  logic [CNTR_WIDTH-1:0]            jump_tgt;
  logic [ADDR_WIDTH-1:0]            alu_op_q;
  logic [DATA_WIDTH-1:0]            operand_q;
  logic [2:0]                       flags_q;   // {gr_z, ls_z, zero}

  logic [ADDR_WIDTH-1:0]            in_op;
  logic [DATA_WIDTH-1:0]            in_opnd;
  logic                             in_is_alu;
  logic [ADDR_WIDTH-1:0]            ir_op;
  logic [DATA_WIDTH-1:0]            ir_opnd;
  logic                             ir_is_alu;
  logic                             jump_taken;

  logic                             fetch_req_c;
  logic                             acc_we_c;
  logic                             halted_c;
  logic                             ir_load;
  logic                             pc_load;

  assign in_op     = bus.instr_in[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
  assign in_opnd   = bus.instr_in[DATA_WIDTH-1:0];
  assign in_is_alu = (in_op <= OP_LDR);

  assign ir_op     = ir[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
  assign ir_opnd   = ir[DATA_WIDTH-1:0];
  assign ir_is_alu = (ir_op <= OP_LDR);

  // Size cast truncates or zero-extends the operand to the PC width.
  assign jump_tgt  = CNTR_WIDTH'(ir_opnd);
  assign pc_plus   = pc + CNTR_WIDTH'(1);

  always_comb begin
    jump_taken = 1'b0;
    case (ir_op)
      OP_JMP:  jump_taken = 1'b1;
      OP_JZ:   jump_taken = flags_q[0];
      OP_JLZ:  jump_taken = flags_q[1];
      OP_JGZ:  jump_taken = flags_q[2];
      default: jump_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    fetch_req_c = 1'b0;
    acc_we_c    = 1'b0;
    halted_c    = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    pc_nxt      = pc_plus;
    case (state)
      S_FETCH: begin
        fetch_req_c = 1'b1;
        if (bus.instr_valid) begin
          ir_load   = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
        pc_load   = 1'b1;
        if (ir_is_alu) begin
          acc_we_c = 1'b1;
        end else if (ir_op == OP_HLT) begin
          pc_load   = 1'b0;
          state_nxt = S_HALT;
        end else if (jump_taken) begin
          pc_nxt = jump_tgt;
        end
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // ALU controls are loaded on the FETCH->DECODE edge straight from
  // instr_in so they are already valid in DECODE and stay put through EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir        <= '0;
      pc        <= '0;
      alu_op_q  <= OP_NOP;
      operand_q <= '0;
      flags_q   <= '0;
    end else begin
      if (ir_load) begin
        ir        <= bus.instr_in;
        alu_op_q  <= in_is_alu ? in_op : OP_NOP;
        operand_q <= in_is_alu ? in_opnd : '0;
      end
      if (pc_load) begin
        pc <= pc_nxt;
      end
      if (acc_we_c) begin
        flags_q <= {bus.gr_z_f, bus.ls_z_f, bus.zero_f};
      end
    end
  end

  assign bus.fetch_req   = fetch_req_c;
  assign bus.pc_out      = pc;
  assign bus.alu_op      = alu_op_q;
  assign bus.operand_out = operand_q;
  assign bus.acc_we      = acc_we_c;
  assign bus.halted      = halted_c;

endmodule

// File: tb/tb_control_seq.sv
module tb_control_seq;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int PC_MOD = 1 << CW;

  localparam int NOP = 0, ADDI = 1, ADDR = 2, SUBI = 3, INC = 11, LDR = 17;
  localparam int JMP = 18, JZ = 19, JLZ = 20, JGZ = 21, HLT = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNTR_WIDTH(CW)) bus ();

  control_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNTR_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Instruction-level reference model
  int m_pc;
  bit m_z, m_l, m_g, m_halt;

  // Observations recorded while an instruction is issued
  int             o_we_cnt, o_we_cyc, o_fetch_bad;
  logic [AW-1:0]  o_op_dec, o_op_exe;
  logic [DW-1:0]  o_opnd_dec, o_opnd_exe;
  logic           o_fr_dec, o_fr_exe;

  int we_rises = 0;
  always @(posedge bus.acc_we) we_rises++;

  function automatic bit is_alu(input int op);
    return op <= LDR;
  endfunction

  function automatic int exp_alu(input int op);
    return is_alu(op) ? op : NOP;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 0; m_z = 0; m_l = 0; m_g = 0; m_halt = 0;
  endtask

  task automatic model_exec(input int op, input int opnd, input bit z, input bit l, input bit g);
    bit taken;
    if (is_alu(op)) begin
      m_z = z; m_l = l; m_g = g;
      m_pc = (m_pc + 1) % PC_MOD;
    end else if (op == HLT) begin
      m_halt = 1;
    end else if (op >= JMP && op <= JGZ) begin
      taken = (op == JMP) || (op == JZ && m_z) || (op == JLZ && m_l) || (op == JGZ && m_g);
      m_pc = taken ? (opnd % PC_MOD) : (m_pc + 1) % PC_MOD;
    end else begin
      m_pc = (m_pc + 1) % PC_MOD;
    end
  endtask

  task automatic note_we(input int cyc);
    if (bus.acc_we === 1'b1) begin
      o_we_cnt++;
      o_we_cyc = cyc;
    end
  endtask

  // Stimulus only: wait cycles, then FETCH(valid), DECODE, EXEC.
  // Cycle numbering: 1 = valid FETCH, 2 = DECODE, 3 = EXEC.
  task automatic issue(input int op, input int opnd, input int waits,
                       input bit z, input bit l, input bit g);
    o_we_cnt = 0; o_we_cyc = -99; o_fetch_bad = 0;
    bus.zero_f = 1'($urandom); bus.ls_z_f = 1'($urandom); bus.gr_z_f = 1'($urandom);
    for (int w = 0; w < waits; w++) begin
      bus.instr_valid = 1'b0;
      bus.instr_in = (AW+DW)'($urandom);
      if (bus.fetch_req !== 1'b1 || bus.pc_out !== CW'(m_pc) || bus.halted !== 1'b0)
        o_fetch_bad++;
      note_we(w - waits + 1);
      step();
    end
    bus.instr_valid = 1'b1;
    bus.instr_in = {AW'(op), DW'(opnd)};
    if (bus.fetch_req !== 1'b1 || bus.pc_out !== CW'(m_pc)) o_fetch_bad++;
    note_we(1);
    step();
    bus.instr_valid = 1'($urandom);
    bus.instr_in = (AW+DW)'($urandom);
    o_op_dec = bus.alu_op; o_opnd_dec = bus.operand_out; o_fr_dec = bus.fetch_req;
    note_we(2);
    step();
    bus.instr_valid = 1'($urandom);
    bus.zero_f = z; bus.ls_z_f = l; bus.gr_z_f = g;
    o_op_exe = bus.alu_op; o_opnd_exe = bus.operand_out; o_fr_exe = bus.fetch_req;
    note_we(3);
    step();
    bus.instr_valid = 1'b0;
  endtask

  task automatic apply_reset();
    bus.instr_valid = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    bus.instr_valid = 1'b0; bus.instr_in = '0;
    bus.zero_f = 0; bus.ls_z_f = 0; bus.gr_z_f = 0;
    rst_n = 1'b0;
    #13;
    total++;
    if (bus.pc_out !== '0 || bus.alu_op !== '0 || bus.operand_out !== '0 ||
        bus.acc_we !== 1'b0 || bus.halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_values pc=%h op=%h opnd=%h we=%b halt=%b required all 0",
               bus.pc_out, bus.alu_op, bus.operand_out, bus.acc_we, bus.halted);
    end
    step();
    rst_n = 1'b1;
    model_reset();
    #1;
    total++;
    if (bus.fetch_req !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_fetch fetch_req=%b required 1", bus.fetch_req);
    end
  endtask

  task automatic test_addi();
    issue(ADDI, 5, 0, 0, 0, 0);
    model_exec(ADDI, 5, 0, 0, 0);
    total++;
    if (o_op_dec !== AW'(ADDI) || o_opnd_dec !== 8'd5) begin
      bad++;
      $display("FAIL addi_decode op=%0d opnd=%0d required 1/5", o_op_dec, o_opnd_dec);
    end
    total++;
    if (o_we_cnt !== 1 || o_we_cyc !== 3) begin
      bad++;
      $display("FAIL addi_we count=%0d cycle=%0d required 1/3", o_we_cnt, o_we_cyc);
    end
    total++;
    if (bus.pc_out !== 8'h01) begin
      bad++;
      $display("FAIL addi_pc pc=%h required 01", bus.pc_out);
    end
  endtask

  task automatic test_wait();
    issue(NOP, 0, 4, 0, 0, 0);
    model_exec(NOP, 0, 0, 0, 0);
    total++;
    if (o_fetch_bad !== 0 || o_we_cnt !== 1 || o_we_cyc !== 3) begin
      bad++;
      $display("FAIL fetch_wait bad_cycles=%0d we_count=%0d we_cycle=%0d required 0/1/3",
               o_fetch_bad, o_we_cnt, o_we_cyc);
    end
    total++;
    if (bus.pc_out !== CW'(m_pc)) begin
      bad++;
      $display("FAIL fetch_wait_pc pc=%h required %h", bus.pc_out, CW'(m_pc));
    end
  endtask

  task automatic test_jz();
    issue(SUBI, 3, 1, 1, 0, 0);
    model_exec(SUBI, 3, 1, 0, 0);
    issue(JZ, 'h20, 2, 0, 1, 1);
    model_exec(JZ, 'h20, 0, 1, 1);
    total++;
    if (bus.pc_out !== 8'h20 || o_we_cnt !== 0 || o_op_dec !== AW'(NOP)) begin
      bad++;
      $display("FAIL jz_taken pc=%h we=%0d op=%0d required 20/0/0", bus.pc_out, o_we_cnt, o_op_dec);
    end
    issue(ADDI, 7, 0, 0, 1, 1);
    model_exec(ADDI, 7, 0, 1, 1);
    issue(JZ, 'h20, 0, 1, 0, 0);
    model_exec(JZ, 'h20, 1, 0, 0);
    total++;
    if (bus.pc_out !== 8'h22) begin
      bad++;
      $display("FAIL jz_not_taken pc=%h required 22", bus.pc_out);
    end
  endtask

  task automatic test_wrap();
    issue(JMP, 'hFF, 0, 0, 0, 0);
    model_exec(JMP, 'hFF, 0, 0, 0);
    total++;
    if (bus.pc_out !== 8'hFF) begin
      bad++;
      $display("FAIL jmp_ff pc=%h required ff", bus.pc_out);
    end
    issue(INC, 0, 0, 0, 0, 0);
    model_exec(INC, 0, 0, 0, 0);
    total++;
    if (bus.pc_out !== 8'h00 || o_we_cnt !== 1) begin
      bad++;
      $display("FAIL pc_wrap pc=%h we=%0d required 00/1", bus.pc_out, o_we_cnt);
    end
  endtask

  task automatic test_unknown();
    issue(ADDI, 1, 0, 0, 0, 1);
    model_exec(ADDI, 1, 0, 0, 1);
    issue(27, 'h55, 0, 1, 1, 0);
    model_exec(27, 'h55, 1, 1, 0);
    total++;
    if (o_we_cnt !== 0 || o_op_dec !== AW'(NOP) || bus.pc_out !== CW'(m_pc)) begin
      bad++;
      $display("FAIL unknown_op we=%0d op=%0d pc=%h required 0/0/%h",
               o_we_cnt, o_op_dec, bus.pc_out, CW'(m_pc));
    end
    issue(JGZ, 'h90, 0, 0, 0, 0);
    model_exec(JGZ, 'h90, 0, 0, 0);
    total++;
    if (bus.pc_out !== 8'h90) begin
      bad++;
      $display("FAIL unknown_keeps_flags pc=%h required 90", bus.pc_out);
    end
  endtask

  task automatic test_random();
    int op, opnd, waits;
    bit z, l, g;
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 31);
      if (op == HLT) op = JLZ;
      opnd = $urandom_range(0, 255);
      waits = $urandom_range(0, 3);
      z = 1'($urandom); l = 1'($urandom); g = 1'($urandom);
      issue(op, opnd, waits, z, l, g);
      model_exec(op, opnd, z, l, g);
      total++;
      if (bus.pc_out !== CW'(m_pc)) begin
        bad++;
        $display("FAIL rand_pc[%0d] op=%0d pc=%h required %h", i, op, bus.pc_out, CW'(m_pc));
      end
      total++;
      if (o_we_cnt !== (is_alu(op) ? 1 : 0) || (is_alu(op) && o_we_cyc !== 3)) begin
        bad++;
        $display("FAIL rand_we[%0d] op=%0d count=%0d cycle=%0d required %0d/3",
                 i, op, o_we_cnt, o_we_cyc, is_alu(op) ? 1 : 0);
      end
      total++;
      if (o_op_dec !== AW'(exp_alu(op)) || o_op_exe !== AW'(exp_alu(op))) begin
        bad++;
        $display("FAIL rand_alu_op[%0d] dec=%0d exe=%0d required %0d",
                 i, o_op_dec, o_op_exe, exp_alu(op));
      end
      if (is_alu(op)) begin
        total++;
        if (o_opnd_dec !== DW'(opnd) || o_opnd_exe !== DW'(opnd)) begin
          bad++;
          $display("FAIL rand_operand[%0d] dec=%h exe=%h required %h",
                   i, o_opnd_dec, o_opnd_exe, DW'(opnd));
        end
      end
      total++;
      if (o_fetch_bad !== 0 || o_fr_dec !== 1'b0 || o_fr_exe !== 1'b0) begin
        bad++;
        $display("FAIL rand_fetch_req[%0d] bad_fetch=%0d dec=%b exe=%b required 0/0/0",
                 i, o_fetch_bad, o_fr_dec, o_fr_exe);
      end
    end
  endtask

  task automatic test_reset_abort();
    int rises;
    issue(JMP, 'h40, 0, 0, 0, 0);
    model_exec(JMP, 'h40, 0, 0, 0);
    bus.instr_valid = 1'b1;
    bus.instr_in = {AW'(ADDR), DW'('h33)};
    step();
    bus.instr_valid = 1'b0;
    step();
    // now in EXEC of ADDr with zero flag presented
    bus.zero_f = 1'b1; bus.ls_z_f = 1'b1; bus.gr_z_f = 1'b1;
    #2;
    rises = we_rises;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.acc_we !== 1'b0 || bus.pc_out !== '0 || bus.alu_op !== '0 ||
        bus.operand_out !== '0 || bus.halted !== 1'b0 || bus.fetch_req !== 1'b1) begin
      bad++;
      $display("FAIL abort_async we=%b pc=%h op=%h opnd=%h halt=%b fr=%b required 0/00/00/00/0/1",
               bus.acc_we, bus.pc_out, bus.alu_op, bus.operand_out, bus.halted, bus.fetch_req);
    end
    step();
    step();
    rst_n = 1'b1;
    model_reset();
    total++;
    if (we_rises !== rises || bus.pc_out !== '0) begin
      bad++;
      $display("FAIL abort_no_we rises=%0d pc=%h required %0d/00", we_rises, bus.pc_out, rises);
    end
    issue(JZ, 'h20, 0, 0, 0, 0);
    model_exec(JZ, 'h20, 0, 0, 0);
    total++;
    if (bus.pc_out !== 8'h01) begin
      bad++;
      $display("FAIL abort_flags_cleared pc=%h required 01", bus.pc_out);
    end
  endtask

  task automatic test_halt();
    int hbad;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      issue(NOP, i, 0, 0, 0, 0);
      model_exec(NOP, i, 0, 0, 0);
    end
    issue(HLT, 'h77, 1, 0, 0, 0);
    model_exec(HLT, 'h77, 0, 0, 0);
    total++;
    if (bus.halted !== 1'b1 || bus.pc_out !== 8'h03 || o_we_cnt !== 0 || m_halt !== 1'b1) begin
      bad++;
      $display("FAIL halt_entry halted=%b pc=%h we=%0d required 1/03/0", bus.halted, bus.pc_out, o_we_cnt);
    end
    hbad = 0;
    for (int i = 0; i < 12; i++) begin
      bus.instr_valid = 1'($urandom);
      bus.instr_in = (AW+DW)'($urandom);
      if (bus.halted !== 1'b1 || bus.pc_out !== 8'h03 || bus.fetch_req !== 1'b0 || bus.acc_we !== 1'b0)
        hbad++;
      step();
    end
    total++;
    if (hbad !== 0) begin
      bad++;
      $display("FAIL halt_hold bad_cycles=%0d required 0", hbad);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_addi();
    test_wait();
    test_jz();
    test_wrap();
    test_unknown();
    test_random();
    test_reset_abort();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_seq.md
CONTROL_SEQ -- requirements
Module: control_seq

Interface
REQ-001 Parameter ADDR_WIDTH, default 5: opcode width; equals the ALU operation port width.
REQ-002 Parameter DATA_WIDTH, default 8: operand/accumulator width.
REQ-003 Parameter CNTR_WIDTH, default 8: program counter width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 instr_in  in  ADDR_WIDTH+DATA_WIDTH  instruction word: opcode in the upper ADDR_WIDTH bits, operand in the lower DATA_WIDTH bits.
REQ-008 instr_valid  in  1  program memory presents a valid word for pc_out.
REQ-009 zero_f, ls_z_f, gr_z_f  in  1 each  ALU result flags.
REQ-010 fetch_req  out  1  request for the word at pc_out.
REQ-011 pc_out  out  CNTR_WIDTH  program counter.
REQ-012 alu_op  out  ADDR_WIDTH  operation driven to the ALU.
REQ-013 operand_out  out  DATA_WIDTH  operand driven to the ALU second input.
REQ-014 acc_we  out  1  one-cycle accumulator write strobe.
REQ-015 halted  out  1  sequencer stopped.

Function
REQ-016 The FSM SHALL have the states FETCH, DECODE, EXEC and HALT, using the shared instruction definitions for opcode decoding.
REQ-017 FETCH: fetch_req=1; on instr_valid=1, latch instr_in into the instruction register and go to DECODE; otherwise hold.
REQ-018 instr_valid SHALL be ignored outside FETCH.
REQ-019 DECODE: drive alu_op=latched opcode and operand_out=latched operand for ALU opcodes (NOP through LDr); for JMP/JZ/JLZ/JGZ/HLT and unknown opcodes drive alu_op=NOP; then go to EXEC.
REQ-020 alu_op and operand_out SHALL be registered and held stable from DECODE through EXEC.
REQ-021 EXEC with an ALU opcode: acc_we=1 for exactly this cycle, capture zero_f/ls_z_f/gr_z_f into a 3-bit flag register, pc <= pc+1, go to FETCH.
REQ-022 The flag register SHALL update only in cycles with acc_we=1.
REQ-023 EXEC with a jump: JMP always taken; JZ/JLZ/JGZ taken when the stored zero/ls_z/gr_z flag is 1; if taken, pc <= operand[CNTR_WIDTH-1:0] (zero-extended when CNTR_WIDTH > DATA_WIDTH), else pc <= pc+1; acc_we=0; go to FETCH.
REQ-024 EXEC with an unknown opcode: acc_we=0, flags unchanged, pc <= pc+1, go to FETCH.
REQ-025 EXEC with HLT: pc unchanged, acc_we=0, go to HALT.
REQ-026 HALT: halted=1, fetch_req=0, acc_we=0; remain until reset.
REQ-027 pc+1 SHALL wrap from 2^CNTR_WIDTH-1 to 0 without a flag.
REQ-028 Minimum latency SHALL be 3 cycles per instruction (FETCH with valid, DECODE, EXEC); each FETCH wait cycle adds one.

Reset
REQ-029 While rst_n=0: state=FETCH, pc_out=0, alu_op=NOP, operand_out=0, acc_we=0, halted=0, flag register=0, instruction register=0.
REQ-030 After rst_n deasserts, fetch_req=1 SHALL be asserted in the first cycle.
REQ-031 Reset asserted mid-instruction SHALL abort the instruction immediately, with no acc_we pulse and no pc update.

Verification
REQ-032 After reset, present ADDi 5 with instr_valid=1 at FETCH -> alu_op=ADDi and operand_out=5 in DECODE; acc_we=1 exactly in the third cycle; pc_out 0->1.
REQ-033 Hold instr_valid=0 for 4 cycles -> stays in FETCH, fetch_req=1, pc_out unchanged, acc_we=0.
REQ-034 ALU op with zero_f=1 at EXEC, then JZ 0x20 -> pc_out=0x20; repeat with zero_f=0 -> pc_out=pc+1.
REQ-035 Set pc to 0xFF via JMP 0xFF, then execute INC -> pc_out wraps to 0x00.
REQ-036 HLT at pc=3 -> halted=1, pc_out=3, fetch_req=0 for 10+ cycles regardless of instr_valid.
REQ-037 Pull rst_n low during the EXEC of ADDr -> acc_we never pulses; all outputs take the REQ-029 values asynchronously.
